// File: rtl/obb_state_driver.sv
// obb_state_driver: per-frame oriented-bounding-box state update.
// A frame tick starts a four-step update: rotate u, accelerate/collide velocity,
// move and bounce position, then commit every output in a single edge.
module obb_state_driver #(
    parameter logic        [15:0] INIT_X   = 16'd20480,
    parameter logic        [15:0] INIT_Y   = 16'd15360,
    parameter logic signed [15:0] ROT_COS  = 16'sd16381,
    parameter logic signed [15:0] ROT_SIN  = 16'sd328,
    parameter logic signed [9:0]  ACCEL    = 10'sd8,
    parameter logic signed [9:0]  VMAX     = 10'sd192,
    parameter logic        [15:0] BOUND_R  = 16'd1280,
    parameter int unsigned        SCREEN_W = 640,
    parameter int unsigned        SCREEN_H = 480
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_tick,
    input  logic               is_collision,
    input  logic               rot_cw,
    input  logic               rot_ccw,
    input  logic        [1:0]  thrust_x,
    input  logic        [1:0]  thrust_y,
    // Positions reach 39680 on the right edge, so they are carried as raw 16-bit Q10.6 words.
    output logic        [15:0] pos_x,
    output logic        [15:0] pos_y,
    output logic signed [15:0] u_x,
    output logic signed [15:0] u_y,
    output logic signed [15:0] v_x,
    output logic signed [15:0] v_y,
    output logic               busy,
    output logic               update_done,
    output logic               overrun
);

    localparam logic signed [15:0] UNIT   = 16'sd16384;
    localparam logic signed [17:0] POS_LO = $signed({2'b00, BOUND_R});
    localparam logic signed [17:0] X_HI   = $signed(18'(SCREEN_W * 64)) - POS_LO;
    localparam logic signed [17:0] Y_HI   = $signed(18'(SCREEN_H * 64)) - POS_LO;

    typedef enum logic [2:0] {S_IDLE, S_ROT, S_ACC, S_MOVE, S_COMMIT} state_t;

    state_t state, next_state;

    logic                accept, do_rot, do_acc, do_move, do_commit;
    logic                cw_q, ccw_q, flip_q, coll_prev;
    logic signed [1:0]   thr_x_q, thr_y_q;
    logic signed [15:0]  u_x_sh, u_y_sh;
    logic        [15:0]  pos_x_sh, pos_y_sh;
    logic signed [9:0]   vel_x, vel_y;

    logic signed [15:0]  sin_eff, rot_x, rot_y;
    logic signed [31:0]  p_xc, p_ys, p_xs, p_yc;
    logic signed [9:0]   vel_x_acc, vel_y_acc, vel_x_mv, vel_y_mv;
    logic        [15:0]  pos_x_mv, pos_y_mv;

    // Round a Q4.28 sum back to Q2.14 and saturate to a unit magnitude.
    function automatic logic signed [15:0] rot_sat(input logic signed [32:0] acc);
        logic signed [32:0] r;
        r = (acc + 33'sd8192) >>> 14;
        if (r > 33'sd16384)       return UNIT;
        else if (r < -33'sd16384) return -UNIT;
        else                      return 16'(r);
    endfunction

    // Limit a velocity sum to [-VMAX, VMAX].
    function automatic logic signed [9:0] clamp_v(input logic signed [11:0] v);
        if (v > 12'(VMAX))       return VMAX;
        else if (v < -12'(VMAX)) return -VMAX;
        else                     return 10'(v);
    endfunction

    // Integrate one axis and reflect velocity off the keep-out margins.
    function automatic void bounce(input logic [15:0] p, input logic signed [9:0] v,
                                   input logic signed [17:0] hi,
                                   output logic [15:0] p_n, output logic signed [9:0] v_n);
        logic signed [17:0] s;
        logic signed [9:0]  a;
        s = $signed({2'b00, p}) + 18'(v);
        a = v[9] ? -v : v;
        if (s < POS_LO) begin
            p_n = BOUND_R;
            v_n = a;
        end else if (s > hi) begin
            p_n = 16'(hi);
            v_n = -a;
        end else begin
            p_n = 16'(s);
            v_n = v;
        end
    endfunction

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    // Next-state logic: fixed four-step sequence once a tick is accepted.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (frame_tick) next_state = S_ROT;
            S_ROT:    next_state = S_ACC;
            S_ACC:    next_state = S_MOVE;
            S_MOVE:   next_state = S_COMMIT;
            S_COMMIT: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Per-state strobes steering the datapath registers.
    always_comb begin
        accept    = 1'b0;
        do_rot    = 1'b0;
        do_acc    = 1'b0;
        do_move   = 1'b0;
        do_commit = 1'b0;
        case (state)
            S_IDLE:   accept    = frame_tick;
            S_ROT:    do_rot    = 1'b1;
            S_ACC:    do_acc    = 1'b1;
            S_MOVE:   do_move   = 1'b1;
            S_COMMIT: do_commit = 1'b1;
            default:  ;
        endcase
    end

    // Datapath: rotation, acceleration with collision flip, and bounded motion.
    always_comb begin
        sin_eff = ccw_q ? -ROT_SIN : ROT_SIN;
        p_xc    = u_x_sh * ROT_COS;
        p_ys    = u_y_sh * sin_eff;
        p_xs    = u_x_sh * sin_eff;
        p_yc    = u_y_sh * ROT_COS;
        rot_x   = u_x_sh;
        rot_y   = u_y_sh;
        if (cw_q ^ ccw_q) begin
            rot_x = rot_sat(33'(p_xc) - 33'(p_ys));
            rot_y = rot_sat(33'(p_xs) + 33'(p_yc));
        end
        vel_x_acc = clamp_v(12'(vel_x) + 12'(thr_x_q) * 12'(ACCEL));
        vel_y_acc = clamp_v(12'(vel_y) + 12'(thr_y_q) * 12'(ACCEL));
        if (flip_q) begin
            vel_x_acc = -vel_x_acc;
            vel_y_acc = -vel_y_acc;
        end
        bounce(pos_x_sh, vel_x, X_HI, pos_x_mv, vel_x_mv);
        bounce(pos_y_sh, vel_y, Y_HI, pos_y_mv, vel_y_mv);
    end

    // Capture per-frame inputs, track busy/overrun and the collision edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cw_q      <= 1'b0;
            ccw_q     <= 1'b0;
            thr_x_q   <= 2'sd0;
            thr_y_q   <= 2'sd0;
            flip_q    <= 1'b0;
            coll_prev <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (accept) begin
                cw_q      <= rot_cw;
                ccw_q     <= rot_ccw;
                thr_x_q   <= $signed(thrust_x);
                thr_y_q   <= $signed(thrust_y);
                flip_q    <= is_collision & ~coll_prev;
                coll_prev <= is_collision;
                busy      <= 1'b1;
            end
            if (do_commit) busy <= 1'b0;
            if (frame_tick && state != S_IDLE) overrun <= 1'b1;
        end
    end

    // Shadow state: rotated axis, velocity (semi-implicit) and position.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            u_x_sh   <= UNIT;
            u_y_sh   <= 16'sd0;
            pos_x_sh <= INIT_X;
            pos_y_sh <= INIT_Y;
            vel_x    <= 10'sd0;
            vel_y    <= 10'sd0;
        end else begin
            if (do_rot) begin
                u_x_sh <= rot_x;
                u_y_sh <= rot_y;
            end
            if (do_acc) begin
                vel_x <= vel_x_acc;
                vel_y <= vel_y_acc;
            end
            if (do_move) begin
                pos_x_sh <= pos_x_mv;
                pos_y_sh <= pos_y_mv;
                vel_x    <= vel_x_mv;
                vel_y    <= vel_y_mv;
            end
        end
    end

    // Atomic commit of every visible output plus the done pulse.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pos_x       <= INIT_X;
            pos_y       <= INIT_Y;
            u_x         <= UNIT;
            u_y         <= 16'sd0;
            v_x         <= 16'sd0;
            v_y         <= UNIT;
            update_done <= 1'b0;
        end else begin
            update_done <= do_commit;
            if (do_commit) begin
                pos_x <= pos_x_sh;
                pos_y <= pos_y_sh;
                u_x   <= u_x_sh;
                u_y   <= u_y_sh;
                v_x   <= -u_y_sh;
                v_y   <= u_x_sh;
            end
        end
    end

endmodule
